// File: rtl/update_dpram_wr_ctrl.sv
// update_dpram_wr_ctrl: packs an update-packet byte stream big-endian into 32-bit
// words for the update-data DPRAM and holds the buffer until the reader releases it.
module update_dpram_wr_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_vld,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic [7:0]        din_data,
    output logic              din_rdy,
    output logic              dp_wren,
    output logic [ADDR_W-1:0] dp_wraddress,
    output logic [31:0]       dp_data,
    output logic              pkt_done,
    output logic [ADDR_W:0]   pkt_words,
    output logic [ADDR_W+2:0] pkt_bytes,
    output logic              pkt_err,
    output logic              buf_full,
    input  logic              buf_release
);
    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W+2:0] LP_MAXB  = (ADDR_W+3)'(4*DEPTH);

    state_t            r_state, w_next;
    logic [7:0]        r_lane [4];
    logic [1:0]        r_cnt, w_p;
    logic [ADDR_W:0]   r_widx, w_widx;
    logic [ADDR_W+2:0] r_bytes;
    logic              r_err, r_pend, r_done, r_wren;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data, w_word;
    logic              w_take, w_disc, w_last, w_wr;

    // A sop byte restarts lane and word index, abandoning any partial word.
    always_comb begin
        w_take = din_vld && r_state != DONE && (r_state == RECV || din_sop);
        w_p    = din_sop ? 2'd0 : r_cnt;
        w_widx = din_sop ? '0 : r_widx;
        w_disc = w_widx == LP_DEPTH && w_p == 2'd0;
        w_last = w_p == 2'd3 || din_eop;
        w_wr   = w_take && !w_disc && w_last;
        w_word = '0;
        for (int k = 0; k < 4; k++)
            w_word[31-8*k -: 8] = (k < int'(w_p)) ? r_lane[k] : (k == int'(w_p)) ? din_data : 8'h00;
        w_next = r_state;
        if (w_take && din_eop)
            w_next = DONE;
        else if (w_take)
            w_next = RECV;
        else if (r_state == DONE && buf_release)
            w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++)
                r_lane[k] <= '0;
            r_cnt   <= '0;
            r_widx  <= '0;
            r_bytes <= '0;
            r_err   <= 1'b0;
            r_pend  <= 1'b0;
            r_done  <= 1'b0;
            r_wren  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_wren <= w_wr;
            r_pend <= w_wr && din_eop;
            // An overflowed eop has no final write, so completion is reported one cycle sooner.
            r_done <= r_pend || (w_take && din_eop && w_disc);
            if (w_wr) begin
                r_addr <= w_widx[ADDR_W-1:0];
                r_data <= w_word;
            end
            if (w_take) begin
                r_lane[w_p] <= din_data;
                r_cnt       <= (w_disc || w_last) ? 2'd0 : w_p + 2'd1;
                r_widx      <= w_wr ? w_widx + 1'b1 : w_widx;
                r_bytes     <= din_sop ? (ADDR_W+3)'(1) : (r_bytes == LP_MAXB) ? r_bytes : r_bytes + 1'b1;
                r_err       <= !din_sop && (r_err || w_disc);
            end else if (r_state == DONE && buf_release) begin
                r_err <= 1'b0;
            end
        end
    end

    assign din_rdy      = r_state != DONE;
    assign buf_full     = r_state == DONE;
    assign dp_wren      = r_wren;
    assign dp_wraddress = r_addr;
    assign dp_data      = r_data;
    assign pkt_done     = r_done;
    assign pkt_words    = r_widx;
    assign pkt_bytes    = r_bytes;
    assign pkt_err      = r_err;
endmodule
